// File: rtl/pipo_load_arbiter.sv
// Load arbiter sharing one two-stage pipo register among NREQ requesters.
// Define PIPO_ARB_RR_EN for round-robin; otherwise fixed lowest-index priority.
module pipo_load_arbiter #(
   parameter int LEN  = 8,
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                accept_i,
   input  logic [NREQ-1:0]     req_valid_i,
   input  logic [NREQ*LEN-1:0] req_data_i,
   output logic [NREQ-1:0]     req_ready_o,
   output logic                pipo_load_o,
   output logic [LEN-1:0]      pipo_data_o,
   output logic                out_valid_o,
   output logic [IDW-1:0]      out_id_o,
   output logic                busy_o
);

   logic [NREQ-1:0] rot;
   logic [IDW-1:0]  off;
   logic            found;
   logic [IDW-1:0]  win;
   logic            grant;
   logic            s1_vld_q;
   logic [IDW-1:0]  s1_id_q;

`ifdef PIPO_ARB_RR_EN
   localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);
   localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);

   logic [IDW-1:0]    ptr_q;
   logic [IDW-1:0]    ptr_d;
   logic [2*NREQ-1:0] dbl;
   logic [IDW:0]      sum;

   // Rotate so that bit 0 is the requester at ptr; the search then wraps.
   assign dbl   = {req_valid_i, req_valid_i};
   assign rot   = NREQ'(dbl >> ptr_q);
   assign sum   = {1'b0, ptr_q} + {1'b0, off};
   assign win   = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : sum[IDW-1:0];
   assign ptr_d = (win == LAST) ? '0 : win + IDW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (grant) begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign rot = req_valid_i;
   assign win = off;
`endif

   always_comb begin
      found = 1'b0;
      off   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            off   = IDW'(k);
         end
      end
   end

   assign grant       = found & accept_i & ~rst;
   assign pipo_load_o = grant;

   always_comb begin
      req_ready_o = '0;
      pipo_data_o = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant && win == IDW'(k)) begin
            req_ready_o[k] = 1'b1;
            pipo_data_o    = req_data_i[k*LEN +: LEN];
         end
      end
   end

   // Mirrors the pipo's two register stages so out_valid lines up with par_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q    <= 1'b0;
         s1_id_q     <= '0;
         out_valid_o <= 1'b0;
         out_id_o    <= '0;
      end else begin
         s1_vld_q    <= grant;
         s1_id_q     <= win;
         out_valid_o <= s1_vld_q;
         out_id_o    <= s1_id_q;
      end
   end

   assign busy_o = s1_vld_q | out_valid_o;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Scoreboard bench for pipo_load_arbiter with a behavioural pipo model.
// Reference grant rule follows PIPO_ARB_RR_EN like the design.
module tb_pipo_load_arbiter;
   localparam int LEN  = 8;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   typedef struct {
      int             id;
      logic [LEN-1:0] data;
      int             due;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                accept = 1'b1;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*LEN-1:0] req_data;
   logic [NREQ-1:0]     req_ready;
   logic                pipo_load;
   logic [LEN-1:0]      pipo_data;
   logic                out_valid;
   logic [IDW-1:0]      out_id;
   logic                busy;
   logic [LEN-1:0]      pipo_q;
   logic [LEN-1:0]      par_out;

   logic           v[NREQ];
   logic [LEN-1:0] d[NREQ];
   exp_t           sb[$];
   int             cyc = 0;
   int             mptr = 0;
   int             gnt = -1;
   int             tests = 0;
   int             fails = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         req_valid[k] = v[k];
         req_data[k*LEN +: LEN] = d[k];
      end
   end

   pipo_load_arbiter #(.LEN(LEN), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk         (clk),
      .rst         (rst),
      .accept_i    (accept),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .pipo_load_o (pipo_load),
      .pipo_data_o (pipo_data),
      .out_valid_o (out_valid),
      .out_id_o    (out_id),
      .busy_o      (busy)
   );

   // Shared holding register: captures on load, par_out one stage later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipo_q  <= '0;
         par_out <= '0;
      end else begin
         if (pipo_load) pipo_q <= pipo_data;
         par_out <= pipo_q;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, act, exp);
      end
   endfunction

   task automatic check();
      int              w;
      logic [NREQ-1:0] er;
      logic [LEN-1:0]  ed;
      w = -1;
      if (!rst && accept) begin
         for (int j = 0; j < NREQ; j++) begin
            int i;
            i = (mptr + j) % NREQ;
            if (w < 0 && v[i]) w = i;
         end
      end
      er = (w >= 0) ? NREQ'(1) << w : '0;
      ed = (w >= 0) ? d[w] : '0;
      cmp("req_ready", 32'(req_ready), 32'(er));
      cmp("pipo_load", 32'(pipo_load), 32'(w >= 0));
      cmp("pipo_data", 32'(pipo_data), 32'(ed));
      if (rst) cmp("rst_out_id", 32'(out_id), 32'd0);
      if (w >= 0) begin
         sb.push_back('{w, d[w], cyc + 2});
`ifdef PIPO_ARB_RR_EN
         mptr = (w + 1) % NREQ;
`endif
      end
      gnt = w;
   endtask

   task automatic step(input logic r, input logic acc, input int pnew,
                       input bit hold, input logic [NREQ-1:0] injm,
                       input logic [LEN-1:0] injd);
      @(posedge clk);
      #1;
      if (gnt >= 0) v[gnt] = 1'b0;
      rst = r;
      if (r) begin
         sb.delete();
         mptr = 0;
      end
      accept = acc;
      for (int i = 0; i < NREQ; i++) begin
         if (!v[i]) begin
            if (hold) begin
               v[i] = 1'b1;
               d[i] = LEN'(8'h10 + i);
            end else if (injm[i]) begin
               v[i] = 1'b1;
               d[i] = injd;
            end else if (int'($urandom_range(99)) < pnew) begin
               v[i] = 1'b1;
               d[i] = LEN'($urandom);
            end
         end
      end
      @(negedge clk);
      check();
   endtask

   always @(negedge clk) begin
      logic eb;
      exp_t e;
      eb = 1'b0;
      foreach (sb[q]) if (sb[q].due == cyc || sb[q].due == cyc + 1) eb = 1'b1;
      cmp("busy", 32'(busy), 32'(eb));
      if (out_valid === 1'b1) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL out_valid cyc=%0d: got 1 want 0", cyc);
         end else begin
            e = sb.pop_front();
            if (e.due != cyc || out_id != IDW'(e.id) || par_out !== e.data) begin
               fails++;
               $display("FAIL out_word cyc=%0d: got id=%0d data=%0h want id=%0d data=%0h due=%0d",
                        cyc, out_id, par_out, e.id, e.data, e.due);
            end
         end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
         tests++;
         fails++;
         $display("FAIL out_valid cyc=%0d: got %b want 1 id=%0d", cyc, out_valid, sb[0].id);
         void'(sb.pop_front());
      end
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         v[i] = 1'b1;
         d[i] = LEN'(8'h10 + i);
      end
      repeat (3) step(1'b1, 1'b1, 0, 1'b1, '0, '0);
      repeat (9) step(1'b0, 1'b1, 0, 1'b1, '0, '0);
      repeat (5) step(1'b0, 1'b1, 0, 1'b0, '0, '0);
      step(1'b0, 1'b1, 0, 1'b0, 4'b0100, 8'hA5);
      repeat (3) step(1'b0, 1'b1, 0, 1'b0, '0, '0);
      step(1'b0, 1'b1, 0, 1'b0, 4'b1010, 8'h3C);
      repeat (2) step(1'b0, 1'b0, 0, 1'b0, '0, '0);
      repeat (4) step(1'b0, 1'b1, 0, 1'b0, '0, '0);
      repeat (2) step(1'b0, 1'b1, 0, 1'b1, '0, '0);
      step(1'b1, 1'b1, 0, 1'b1, '0, '0);
      repeat (3) step(1'b0, 1'b1, 0, 1'b1, '0, '0);
      repeat (6) step(1'b0, 1'b1, 0, 1'b0, '0, '0);
      repeat (400) step(1'b0, $urandom_range(9) < 8, 35, 1'b0, '0, '0);
      repeat (12) step(1'b0, 1'b1, 0, 1'b0, '0, '0);
      cmp("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
